// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and counter sizing for reset_sequencer
package reset_seq_pkg;
  typedef enum logic [2:0] {HOLD, DELAY, WAIT_READY, DONE, ASSERT, FAULT} state_t;
  function automatic int cnt_w(input int a, input int b);
    return (a > b ? a : b) > 1 ? $clog2(a > b ? a : b) : 1;
  endfunction
endpackage

// File: rtl/async_reset_synchronizer.sv
// async_reset_synchronizer: immediate assertion, two-flop synchronized release
module async_reset_synchronizer (
  input  logic clk,
  input  logic asyncrst_n,
  output logic rst_n
);
  logic [1:0] r_sync;
  always_ff @(posedge clk or negedge asyncrst_n)
    if (!asyncrst_n) r_sync <= '0;
    else r_sync <= {r_sync[0], 1'b1};
  assign rst_n = r_sync[1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered per-domain reset release with ready handshake, timeout fault and soft restart
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int DELAY_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  asyncrst_n,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  all_released,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int CW = cnt_w(DELAY_CYCLES, TIMEOUT_CYCLES);
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);
  localparam logic [IW-1:0] IDX_REV  = IW'(NUM_STAGES - 2);
  if (NUM_STAGES < 1) begin : g_bad_stages
    $error("NUM_STAGES must be >= 1");
  end
  if (DELAY_CYCLES < 1) begin : g_bad_delay
    $error("DELAY_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end
  logic                  w_rst_n;
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [NUM_STAGES-1:0] r_rst;
  logic                  r_all;
  logic                  r_busy;
  logic                  r_err;
  async_reset_synchronizer u_sync (
    .clk       (clk),
    .asyncrst_n(asyncrst_n),
    .rst_n     (w_rst_n)
  );
  // Outputs are updated on the transition into each state so they stay purely registered.
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= '0;
      r_all   <= 1'b0;
      r_busy  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_rst   <= '0;
          r_state <= soft_rst_req ? HOLD : DELAY;
        end
        DELAY:
          if (soft_rst_req) begin
            r_rst   <= '0;
            r_cnt   <= '0;
            r_state <= HOLD;
          end else if (r_cnt == DLY_LAST) begin
            r_rst[r_idx] <= 1'b1;
            r_cnt        <= '0;
            r_state      <= WAIT_READY;
          end else r_cnt <= r_cnt + CW'(1);
        WAIT_READY:
          if (soft_rst_req) begin
            r_rst   <= '0;
            r_cnt   <= '0;
            r_state <= HOLD;
          end else if (stage_ready[r_idx]) begin
            if (r_idx == IDX_LAST) begin
              r_all   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_cnt   <= '0;
              r_state <= DELAY;
            end
          end else if (r_cnt == TO_LAST) begin
            r_rst   <= '0;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= FAULT;
          end else r_cnt <= r_cnt + CW'(1);
        DONE:
          if (soft_rst_req) begin
            r_all  <= 1'b0;
            r_busy <= 1'b1;
            if (NUM_STAGES == 1) begin
              r_rst   <= '0;
              r_state <= HOLD;
            end else begin
              r_rst[NUM_STAGES-1] <= 1'b0;
              r_idx               <= IDX_REV;
              r_state             <= ASSERT;
            end
          end
        ASSERT: begin
          r_rst[r_idx] <= 1'b0;
          r_idx        <= r_idx - IW'(1);
          r_state      <= r_idx == '0 ? HOLD : ASSERT;
        end
        FAULT:
          if (soft_rst_req) begin
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= HOLD;
          end
        default: r_state <= HOLD;
      endcase
    end
  assign rst_n_out    = r_rst;
  assign all_released = r_all;
  assign busy         = r_busy;
  assign timeout_err  = r_err;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench, expected output snapshots queued per clk edge
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       asyncrst_n = 1'b0;
  logic [3:0] stage_ready = 4'hF;
  logic       soft_rst_req = 1'b0;
  logic [3:0] rst_n_out;
  logic       all_released, busy, timeout_err;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       all, bsy, err;
  } exp_t;
  exp_t sb[$];

  reset_sequencer dut (
    .clk         (clk),
    .asyncrst_n  (asyncrst_n),
    .stage_ready (stage_ready),
    .soft_rst_req(soft_rst_req),
    .rst_n_out   (rst_n_out),
    .all_released(all_released),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] r, input logic a, input logic b, input logic e);
    sb.push_back('{c, r, a, b, e});
  endtask

  // Full release sequence with all stages ready, measured from the edge that (re)enters HOLD.
  task automatic push_seq(input int b);
    push(b, 4'h0, 0, 1, 0);
    push(b + 16, 4'h0, 0, 1, 0);
    push(b + 17, 4'h1, 0, 1, 0);
    push(b + 33, 4'h1, 0, 1, 0);
    push(b + 34, 4'h3, 0, 1, 0);
    push(b + 51, 4'h7, 0, 1, 0);
    push(b + 67, 4'h7, 0, 1, 0);
    push(b + 68, 4'hF, 0, 1, 0);
    push(b + 69, 4'hF, 1, 0, 0);
  endtask

  task automatic pulse_soft(output int s);
    soft_rst_req = 1'b1;
    @(posedge clk);
    #1 soft_rst_req = 1'b0;
    s = cyc;
  endtask

  task automatic push_reverse(input int s);
    push(s, 4'h7, 0, 1, 0);
    push(s + 1, 4'h3, 0, 1, 0);
    push(s + 2, 4'h1, 0, 1, 0);
  endtask

  task automatic test_reset();
    exp_t e;
    int   r;
    repeat (3) @(negedge clk);
    checks++;
    if ({rst_n_out, all_released, busy, timeout_err} !== 7'b0000_010) begin
      errors++;
      $display("FAIL reset_hold: got rst=%b all=%b busy=%b err=%b, want 0000 0 1 0", rst_n_out, all_released, busy, timeout_err);
    end
    asyncrst_n = 1'b1;
    r = cyc + 2;
    push_seq(r);
    for (int n = 0; n < 200 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {rst_n_out, all_released, busy, timeout_err} !== {e.rst, e.all, e.bsy, e.err}) begin
          errors++;
          $display("FAIL power_up edge %0d: got rst=%b all=%b busy=%b err=%b, want rst=%b all=%b busy=%b err=%b", e.cyc, rst_n_out, all_released, busy, timeout_err, e.rst, e.all, e.bsy, e.err);
        end
      end
    end
    if (sb.size() > 0) begin
      errors++; checks++;
      $display("FAIL power_up: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_soft_done();
    exp_t e;
    int   s;
    pulse_soft(s);
    push_reverse(s);
    push_seq(s + 3);
    for (int n = 0; n < 200 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {rst_n_out, all_released, busy, timeout_err} !== {e.rst, e.all, e.bsy, e.err}) begin
          errors++;
          $display("FAIL soft_done edge %0d: got rst=%b all=%b busy=%b err=%b, want rst=%b all=%b busy=%b err=%b", e.cyc, rst_n_out, all_released, busy, timeout_err, e.rst, e.all, e.bsy, e.err);
        end
      end
    end
    if (sb.size() > 0) begin
      errors++; checks++;
      $display("FAIL soft_done: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_fault();
    exp_t e;
    int   s, b;
    stage_ready = 4'b1101;
    pulse_soft(s);
    push_reverse(s);
    b = s + 3;
    push(b, 4'h0, 0, 1, 0);
    push(b + 17, 4'h1, 0, 1, 0);
    push(b + 34, 4'h3, 0, 1, 0);
    push(b + 34 + 1023, 4'h3, 0, 1, 0);
    push(b + 34 + 1024, 4'h0, 0, 0, 1);
    push(b + 34 + 1030, 4'h0, 0, 0, 1);
    for (int n = 0; n < 1500 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {rst_n_out, all_released, busy, timeout_err} !== {e.rst, e.all, e.bsy, e.err}) begin
          errors++;
          $display("FAIL fault edge %0d: got rst=%b all=%b busy=%b err=%b, want rst=%b all=%b busy=%b err=%b", e.cyc, rst_n_out, all_released, busy, timeout_err, e.rst, e.all, e.bsy, e.err);
        end
      end
    end
    stage_ready = 4'hF;
    pulse_soft(s);
    push_seq(s);
    for (int n = 0; n < 200 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {rst_n_out, all_released, busy, timeout_err} !== {e.rst, e.all, e.bsy, e.err}) begin
          errors++;
          $display("FAIL fault_recover edge %0d: got rst=%b all=%b busy=%b err=%b, want rst=%b all=%b busy=%b err=%b", e.cyc, rst_n_out, all_released, busy, timeout_err, e.rst, e.all, e.bsy, e.err);
        end
      end
    end
    if (sb.size() > 0) begin
      errors++; checks++;
      $display("FAIL fault: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout_race();
    exp_t e;
    int   s, b, t;
    stage_ready = 4'b1011;
    pulse_soft(s);
    push_reverse(s);
    b = s + 3;
    t = b + 51 + 1024;
    push(b + 34, 4'h3, 0, 1, 0);
    push(b + 51, 4'h7, 0, 1, 0);
    push(t - 1, 4'h7, 0, 1, 0);
    for (int n = 0; n < 1500 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {rst_n_out, all_released, busy, timeout_err} !== {e.rst, e.all, e.bsy, e.err}) begin
          errors++;
          $display("FAIL race_wait edge %0d: got rst=%b all=%b busy=%b err=%b, want rst=%b all=%b busy=%b err=%b", e.cyc, rst_n_out, all_released, busy, timeout_err, e.rst, e.all, e.bsy, e.err);
        end
      end
    end
    stage_ready = 4'hF;
    push(t, 4'h7, 0, 1, 0);
    push(t + 15, 4'h7, 0, 1, 0);
    push(t + 16, 4'hF, 0, 1, 0);
    push(t + 17, 4'hF, 1, 0, 0);
    for (int n = 0; n < 100 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {rst_n_out, all_released, busy, timeout_err} !== {e.rst, e.all, e.bsy, e.err}) begin
          errors++;
          $display("FAIL race_release edge %0d: got rst=%b all=%b busy=%b err=%b, want rst=%b all=%b busy=%b err=%b", e.cyc, rst_n_out, all_released, busy, timeout_err, e.rst, e.all, e.bsy, e.err);
        end
      end
    end
    if (sb.size() > 0) begin
      errors++; checks++;
      $display("FAIL timeout_race: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_soft_wait();
    exp_t e;
    int   s, b;
    stage_ready = 4'b1101;
    pulse_soft(s);
    push_reverse(s);
    b = s + 3;
    push(b + 34, 4'h3, 0, 1, 0);
    push(b + 40, 4'h3, 0, 1, 0);
    for (int n = 0; n < 200 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {rst_n_out, all_released, busy, timeout_err} !== {e.rst, e.all, e.bsy, e.err}) begin
          errors++;
          $display("FAIL soft_wait_pre edge %0d: got rst=%b all=%b busy=%b err=%b, want rst=%b all=%b busy=%b err=%b", e.cyc, rst_n_out, all_released, busy, timeout_err, e.rst, e.all, e.bsy, e.err);
        end
      end
    end
    stage_ready = 4'hF;
    pulse_soft(s);
    push_seq(s);
    for (int n = 0; n < 200 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {rst_n_out, all_released, busy, timeout_err} !== {e.rst, e.all, e.bsy, e.err}) begin
          errors++;
          $display("FAIL soft_wait edge %0d: got rst=%b all=%b busy=%b err=%b, want rst=%b all=%b busy=%b err=%b", e.cyc, rst_n_out, all_released, busy, timeout_err, e.rst, e.all, e.bsy, e.err);
        end
      end
    end
    if (sb.size() > 0) begin
      errors++; checks++;
      $display("FAIL soft_wait: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_async_mid();
    exp_t e;
    int   s, r;
    pulse_soft(s);
    push_reverse(s);
    push(s + 3 + 20, 4'h1, 0, 1, 0);
    for (int n = 0; n < 200 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {rst_n_out, all_released, busy, timeout_err} !== {e.rst, e.all, e.bsy, e.err}) begin
          errors++;
          $display("FAIL async_pre edge %0d: got rst=%b all=%b busy=%b err=%b, want rst=%b all=%b busy=%b err=%b", e.cyc, rst_n_out, all_released, busy, timeout_err, e.rst, e.all, e.bsy, e.err);
        end
      end
    end
    #1 asyncrst_n = 1'b0;
    #1;
    checks++;
    if ({rst_n_out, all_released, busy, timeout_err} !== 7'b0000_010) begin
      errors++;
      $display("FAIL async_assert: got rst=%b all=%b busy=%b err=%b, want 0000 0 1 0", rst_n_out, all_released, busy, timeout_err);
    end
    #1 asyncrst_n = 1'b1;
    r = cyc + 2;
    push_seq(r);
    for (int n = 0; n < 200 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {rst_n_out, all_released, busy, timeout_err} !== {e.rst, e.all, e.bsy, e.err}) begin
          errors++;
          $display("FAIL async_rerun edge %0d: got rst=%b all=%b busy=%b err=%b, want rst=%b all=%b busy=%b err=%b", e.cyc, rst_n_out, all_released, busy, timeout_err, e.rst, e.all, e.bsy, e.err);
        end
      end
    end
    if (sb.size() > 0) begin
      errors++; checks++;
      $display("FAIL async_mid: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_soft_done();
    test_fault();
    test_timeout_race();
    test_soft_wait();
    test_async_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences release of NUM_STAGES downstream reset domains in a fixed order from one asynchronous board reset. Each stage is released after a programmable delay and must report ready before the next stage is released. Missing ready within a timeout raises a sticky fault. A software request re-asserts the domains in reverse order and reruns the sequence. The block sits at the top of the clock/reset tree and feeds downstream per-domain reset synchronizers.

## Interface
- NUM_STAGES, 4: number of sequenced reset outputs; legal ≥1.
- DELAY_CYCLES, 16: clk cycles spent in DELAY before each stage release; legal ≥1.
- TIMEOUT_CYCLES, 1024: maximum clk cycles in WAIT_READY; legal ≥2.
- clk  in  1  single clock for all logic.
- asyncrst_n  in  1  reset, asynchronous, active-low; assertion is immediate, release is synchronized internally.
- stage_ready  in  NUM_STAGES  per-stage ready (e.g. PLL lock, init done); synchronous to clk.
- soft_rst_req  in  1  one-cycle pulse requesting a full reset cycle.
- rst_n_out  out  NUM_STAGES  per-stage active-low reset; bit 0 is released first.
- all_released  out  1  high only in DONE.
- busy  out  1  high in every state except DONE and FAULT.
- timeout_err  out  1  sticky; high in FAULT.

## Operation
- Internal reset rst_n comes from a two-flop synchronizer on asyncrst_n. All state is cleared by rst_n.
- Reset values: rst_n_out=0, all_released=0, busy=1, timeout_err=0, state HOLD, idx=0, cnt=0.
- States:
  - HOLD: clear cnt and idx, then go to DELAY after 1 cycle.
  - DELAY: increment cnt. At cnt==DELAY_CYCLES-1, set rst_n_out[idx]=1, clear cnt, and go to WAIT_READY.
  - WAIT_READY: if stage_ready[idx] is high, go to DONE when idx==NUM_STAGES-1; otherwise increment idx, clear cnt, and go to DELAY. If ready is low and cnt==TIMEOUT_CYCLES-1, go to FAULT. Otherwise increment cnt.
  - DONE: all_released=1. stage_ready is ignored. On soft_rst_req, clear rst_n_out[NUM_STAGES-1], set idx=NUM_STAGES-2, and go to ASSERT. When NUM_STAGES==1, go directly to HOLD.
  - ASSERT: each cycle, clear rst_n_out[idx] and decrement idx. After clearing bit 0, go to HOLD.
  - FAULT: rst_n_out=0 and timeout_err=1. soft_rst_req clears timeout_err and goes to HOLD.
- soft_rst_req in HOLD, DELAY or WAIT_READY forces rst_n_out to 0 on the same edge and goes to HOLD. In ASSERT it is ignored.
- Simultaneous events in WAIT_READY: ready seen on the timeout cycle wins, so no fault is raised.
- Asserting asyncrst_n at any time, including mid-sequence, drives rst_n_out to 0 asynchronously and returns all state to reset values.
- Width rules:
  - cnt width is $clog2(max(DELAY_CYCLES,TIMEOUT_CYCLES)).
  - idx width is $clog2(NUM_STAGES), minimum 1.
  - Counters never wrap: they are cleared on every state entry.

## Timing
- R is the edge at which internal rst_n rises, which is the 2nd clk edge after asyncrst_n deasserts.
- With stage_ready already high, stage k releases at edge R+1+(k+1)·DELAY_CYCLES+k.
- DONE (all_released=1) is entered at the edge after the last release.
- Worked example, defaults: releases at R+17, R+34, R+51, R+68; all_released at R+69.
- FAULT is entered TIMEOUT_CYCLES edges after entering WAIT_READY.
- Reverse assertion: NUM_STAGES edges from the edge sampling soft_rst_req until all outputs are low. The next edge enters DELAY.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- reset_seq_pkg holds:
  - the state enum: HOLD, DELAY, WAIT_READY, DONE, ASSERT, FAULT;
  - a cnt-width helper function.
- One sub-module instance: async_reset_synchronizer (clk, asyncrst_n → internal rst_n).
- Parameter legality is checked with elaboration-time assertions.

## Test plan
- Power-up, defaults, stage_ready=4'hF: rst_n_out goes 0001/0011/0111/1111 at R+17/34/51/68; all_released=1 and busy=0 at R+69.
- stage_ready[1] held low: stage 1 releases at R+34 and stage 2 is never released. FAULT at R+34+1024: rst_n_out=0, timeout_err=1. soft_rst_req then clears the error and the sequence reruns.
- stage_ready[2] rises exactly on the timeout cycle: no fault, and stage 3 releases DELAY_CYCLES+1 edges later.
- soft_rst_req in DONE: rst_n_out goes 0111, 0011, 0001, 0000 on consecutive edges, then the full sequence repeats with the same offsets.
- soft_rst_req in WAIT_READY of stage 1: rst_n_out=0 on the next edge, then a restart from HOLD.
- asyncrst_n pulsed low mid-DELAY without a clk edge: rst_n_out=0 immediately. After release the timing matches power-up.
